pipeline_hazard_sequencer: RTL and testbench

//  Registered scoreboard and sequencer for the 5-stage pipeline's hazard handling. Tracks destination

---
 rtl/pipeline_hazard_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_pipeline_hazard_sequencer.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_sequencer.sv
// pipeline_hazard_sequencer: RAW scoreboard plus stall / jump-squash / branch-flush sequencing
// for the 5-stage pipeline. Control outputs are combinational from sequencer state and inputs.
module pipeline_hazard_sequencer #(
  parameter int unsigned SB_DEPTH     = 3,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      id_instr,
  input  logic             id_valid,
  input  logic             ex_branch_taken,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_nop,
  output logic             idex_nop,
  output logic             exmem_nop,
  output logic [1:0]       seq_state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned REG_W  = 5;
  localparam int unsigned FCNT_W = 2;
  localparam int unsigned SB_W   = REG_W * SB_DEPTH;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [FCNT_W-1:0] FLUSH_RELOAD = FCNT_W'(FLUSH_CYCLES - 1);
  localparam logic              FLUSH_MULTI  = (FLUSH_CYCLES > 1);
  localparam logic [CNT_W-1:0]  CNT_MAX      = '1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [FCNT_W-1:0]   fcnt;
  logic [FCNT_W-1:0]   fcnt_nxt;

  logic [SB_DEPTH-1:0]            sb_v;
  logic [SB_DEPTH-1:0][REG_W-1:0] sb_r;
  logic [SB_DEPTH-1:0]            sb_hit;

  logic [5:0]       op;
  logic [REG_W-1:0] rs;
  logic [REG_W-1:0] rt;
  logic [REG_W-1:0] rd;
  logic             dst_v;
  logic [REG_W-1:0] dst;
  logic             src1_v;
  logic             src2_v;
  logic             hazard;
  logic             is_jump;

  logic act_branch;
  logic act_flush;
  logic act_stall;
  logic act_jump;
  logic act_issue;
  logic sb_in_v;

  logic unused_imm;

  assign op         = id_instr[31:26];
  assign rs         = id_instr[25:21];
  assign rt         = id_instr[20:16];
  assign rd         = id_instr[15:11];
  assign unused_imm = ^id_instr[10:0];

  // Destination / source decode; $0 is neither recorded nor hazard-checked.
  always_comb begin
    dst_v  = 1'b0;
    dst    = '0;
    src1_v = 1'b0;
    src2_v = 1'b0;
    case (op)
      OP_RTYPE: begin
        dst_v  = 1'b1;
        dst    = rd;
        src1_v = 1'b1;
        src2_v = 1'b1;
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LW: begin
        dst_v  = 1'b1;
        dst    = rt;
        src1_v = 1'b1;
      end
      OP_SW, OP_BEQ, OP_BNE: begin
        src1_v = 1'b1;
        src2_v = 1'b1;
      end
      default: begin
        dst_v = 1'b0;
      end
    endcase
    dst_v  = dst_v  && (dst != '0);
    src1_v = src1_v && (rs  != '0);
    src2_v = src2_v && (rt  != '0);
  end

  // Per-entry RAW match against the unforwarded in-flight destinations.
  for (genvar k = 0; k < SB_DEPTH; k++) begin : g_cmp
    assign sb_hit[k] = sb_v[k] && ((src1_v && (sb_r[k] == rs)) || (src2_v && (sb_r[k] == rt)));
  end

  assign hazard  = id_valid && (|sb_hit);
  assign is_jump = id_valid && (op == OP_J);

  // Priority: taken branch > flush in progress > RAW stall > jump > normal issue.
  assign act_branch = ex_branch_taken;
  assign act_flush  = !ex_branch_taken && (state == ST_FLUSH);
  assign act_stall  = !ex_branch_taken && (state != ST_FLUSH) && hazard;
  assign act_jump   = !ex_branch_taken && (state != ST_FLUSH) && !hazard && is_jump;
  assign act_issue  = !act_branch && !act_flush && !act_stall;
  assign sb_in_v    = act_issue && id_valid && dst_v;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_RUN;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = ST_RUN;
    fcnt_nxt  = fcnt;
    if (act_branch) begin
      if (FLUSH_MULTI) begin
        state_nxt = ST_FLUSH;
        fcnt_nxt  = FLUSH_RELOAD;
      end else begin
        fcnt_nxt  = '0;
      end
    end else if (act_flush) begin
      fcnt_nxt  = fcnt - FCNT_W'(1);
      state_nxt = (fcnt_nxt == '0) ? ST_RUN : ST_FLUSH;
    end else if (act_stall) begin
      state_nxt = ST_STALL;
    end
  end

  // Output logic; reset forces the free-running RUN controls.
  always_comb begin
    pc_en     = 1'b1;
    ifid_en   = 1'b1;
    ifid_nop  = 1'b0;
    idex_nop  = 1'b0;
    exmem_nop = 1'b0;
    if (!reset) begin
      if (act_branch) begin
        ifid_nop  = 1'b1;
        idex_nop  = 1'b1;
        exmem_nop = 1'b1;
      end else if (act_flush) begin
        ifid_nop  = 1'b1;
        idex_nop  = 1'b1;
      end else if (act_stall) begin
        pc_en     = 1'b0;
        ifid_en   = 1'b0;
        idex_nop  = 1'b1;
      end else if (act_jump) begin
        ifid_nop  = 1'b1;
      end
    end
  end

  assign seq_state = state;

  // Scoreboard shifts every cycle; the oldest entry falls off the top.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_v <= '0;
      sb_r <= '0;
    end else begin
      sb_v <= SB_DEPTH'({sb_v, sb_in_v});
      sb_r <= SB_W'({sb_r, dst});
    end
  end

  // Saturating event counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (act_stall && (stall_count != CNT_MAX)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
      if (act_branch && (flush_count != CNT_MAX)) begin
        flush_count <= flush_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Bench for pipeline_hazard_sequencer: directed hazard/flush/jump scenarios plus a randomized
// run checked against an issue-history reference model.
module tb_pipeline_hazard_sequencer;

  localparam int unsigned SB_D = 3;
  localparam int unsigned FC   = 2;
  localparam int unsigned CW   = 4;
  localparam int          CMAX = (1 << CW) - 1;
  localparam logic [31:0] NOP  = 32'hFC000000;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   id_instr;
  logic          id_valid;
  logic          ex_branch_taken;
  logic          pc_en;
  logic          ifid_en;
  logic          ifid_nop;
  logic          idex_nop;
  logic          exmem_nop;
  logic [1:0]    seq_state;
  logic [CW-1:0] stall_count;
  logic [CW-1:0] flush_count;

  int checks   = 0;
  int failures = 0;

  // Reference model: destinations issued in the last SB_D cycles (newest first, 0 = none).
  int m_sb[$];
  int m_mode    = 0;
  int m_fleft   = 0;
  int m_stalls  = 0;
  int m_flushes = 0;

  pipeline_hazard_sequencer #(
    .SB_DEPTH    (SB_D),
    .FLUSH_CYCLES(FC),
    .CNT_W       (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .id_instr       (id_instr),
    .id_valid       (id_valid),
    .ex_branch_taken(ex_branch_taken),
    .pc_en          (pc_en),
    .ifid_en        (ifid_en),
    .ifid_nop       (ifid_nop),
    .idex_nop       (idex_nop),
    .exmem_nop      (exmem_nop),
    .seq_state      (seq_state),
    .stall_count    (stall_count),
    .flush_count    (flush_count)
  );

  always #5 clk = ~clk;

  function automatic void decode(input logic [31:0] ins, output int dst, output int s1,
                                 output int s2);
    int rs;
    int rt;
    int rd;
    rs  = int'(ins[25:21]);
    rt  = int'(ins[20:16]);
    rd  = int'(ins[15:11]);
    dst = 0;
    s1  = 0;
    s2  = 0;
    case (ins[31:26])
      6'h00:                             begin dst = rd; s1 = rs; s2 = rt; end
      6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h23: begin dst = rt; s1 = rs; end
      6'h2B, 6'h04, 6'h05:               begin s1 = rs; s2 = rt; end
      default: ;
    endcase
  endfunction

  // 0 branch, 1 flush, 2 stall, 3 jump, 4 normal
  function automatic int m_action();
    int dst;
    int s1;
    int s2;
    bit raw;
    raw = 1'b0;
    if (ex_branch_taken) return 0;
    if (m_mode == 2) return 1;
    decode(id_instr, dst, s1, s2);
    foreach (m_sb[i]) if (m_sb[i] != 0 && (m_sb[i] == s1 || m_sb[i] == s2)) raw = 1'b1;
    if (id_valid && raw) return 2;
    if (id_valid && id_instr[31:26] == 6'h02) return 3;
    return 4;
  endfunction

  // Expected {pc_en, ifid_en, ifid_nop, idex_nop, exmem_nop}.
  function automatic logic [4:0] m_expect();
    if (reset) return 5'b11000;
    case (m_action())
      0:       return 5'b11111;
      1:       return 5'b11110;
      2:       return 5'b00010;
      3:       return 5'b11100;
      default: return 5'b11000;
    endcase
  endfunction

  function automatic void m_reset();
    m_sb.delete();
    m_mode    = 0;
    m_fleft   = 0;
    m_stalls  = 0;
    m_flushes = 0;
  endfunction

  function automatic void m_step();
    int act;
    int dst;
    int s1;
    int s2;
    act = m_action();
    decode(id_instr, dst, s1, s2);
    m_sb.push_front((act >= 3 && id_valid) ? dst : 0);
    if (m_sb.size() > int'(SB_D)) void'(m_sb.pop_back());
    case (act)
      0: begin
        m_flushes = (m_flushes < CMAX) ? m_flushes + 1 : CMAX;
        m_fleft   = int'(FC) - 1;
        m_mode    = (m_fleft > 0) ? 2 : 0;
      end
      1: begin
        m_fleft = m_fleft - 1;
        m_mode  = (m_fleft > 0) ? 2 : 0;
      end
      2: begin
        m_stalls = (m_stalls < CMAX) ? m_stalls + 1 : CMAX;
        m_mode   = 1;
      end
      default: m_mode = 0;
    endcase
  endfunction

  task automatic drive(input logic [31:0] ins, input logic v, input logic br);
    id_instr        = ins;
    id_valid        = v;
    ex_branch_taken = br;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) m_reset();
    else m_step();
    #1;
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    id_instr        = NOP;
    id_valid        = 1'b0;
    ex_branch_taken = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    drive(32'h00221820, 1'b1, 1'b0);
    tick();
    drive(32'h00642820, 1'b1, 1'b0);
    checks++;
    if ({pc_en, ifid_en, ifid_nop, idex_nop, exmem_nop} !== 5'b00010) begin
      failures++;
      $display("FAIL reset_prestall ctl=%b want=00010", {pc_en, ifid_en, ifid_nop, idex_nop, exmem_nop});
    end
    tick();
    id_instr = 32'h00642820;
    #2 reset = 1'b1;
    m_reset();
    #1;
    checks++;
    if ({pc_en, ifid_en, ifid_nop, idex_nop, exmem_nop} !== 5'b11000 || seq_state !== 2'b00 ||
        stall_count !== '0 || flush_count !== '0) begin
      failures++;
      $display("FAIL reset_mid_stall ctl=%b st=%b sc=%0d fc=%0d want ctl=11000 st=00 sc=0 fc=0",
               {pc_en, ifid_en, ifid_nop, idex_nop, exmem_nop}, seq_state, stall_count, flush_count);
    end
    tick();
    #2 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({pc_en, ifid_en, ifid_nop, idex_nop, exmem_nop} !== 5'b11000 || seq_state !== 2'b00) begin
      failures++;
      $display("FAIL reset_residual ctl=%b st=%b want ctl=11000 st=00",
               {pc_en, ifid_en, ifid_nop, idex_nop, exmem_nop}, seq_state);
    end
    tick();
  endtask

  task automatic test_raw_stall();
    logic [4:0] want [5]    = '{5'b11000, 5'b00010, 5'b00010, 5'b00010, 5'b11000};
    logic [1:0] want_st [5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive((i == 0) ? 32'h00221820 : 32'h00642820, 1'b1, 1'b0);
      checks++;
      if ({pc_en, ifid_en, ifid_nop, idex_nop, exmem_nop} !== want[i] || seq_state !== want_st[i]) begin
        failures++;
        $display("FAIL raw_stall cyc%0d ctl=%b st=%b want ctl=%b st=%b", i,
                 {pc_en, ifid_en, ifid_nop, idex_nop, exmem_nop}, seq_state, want[i], want_st[i]);
      end
      tick();
    end
    checks++;
    if (stall_count !== 4'd3 || seq_state !== 2'b00) begin
      failures++;
      $display("FAIL raw_stall_count sc=%0d st=%b want sc=3 st=00", stall_count, seq_state);
    end
  endtask

  task automatic test_zero_reg();
    logic [31:0] seq [3] = '{32'h20000005, 32'h00042820, 32'h00042820};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(seq[i], 1'b1, 1'b0);
      checks++;
      if ({pc_en, ifid_en, ifid_nop, idex_nop, exmem_nop} !== 5'b11000 || seq_state !== 2'b00) begin
        failures++;
        $display("FAIL zero_reg cyc%0d ctl=%b st=%b want ctl=11000 st=00", i,
                 {pc_en, ifid_en, ifid_nop, idex_nop, exmem_nop}, seq_state);
      end
      tick();
    end
    checks++;
    if (stall_count !== 4'd0) begin
      failures++;
      $display("FAIL zero_reg_count sc=%0d want 0", stall_count);
    end
  endtask

  task automatic test_lw_sw();
    logic [31:0] seq [6]    = '{32'h8C240000, 32'hAC440004, 32'hAC440004, 32'hAC440004,
                                32'hAC440004, 32'h00843020};
    logic [4:0]  want [6]   = '{5'b11000, 5'b00010, 5'b00010, 5'b00010, 5'b11000, 5'b11000};
    logic [1:0]  want_st [6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(seq[i], 1'b1, 1'b0);
      checks++;
      if ({pc_en, ifid_en, ifid_nop, idex_nop, exmem_nop} !== want[i] || seq_state !== want_st[i]) begin
        failures++;
        $display("FAIL lw_sw cyc%0d ctl=%b st=%b want ctl=%b st=%b", i,
                 {pc_en, ifid_en, ifid_nop, idex_nop, exmem_nop}, seq_state, want[i], want_st[i]);
      end
      tick();
    end
    checks++;
    if (stall_count !== 4'd3) begin
      failures++;
      $display("FAIL lw_sw_count sc=%0d want 3", stall_count);
    end
  endtask

  task automatic test_branch_flush();
    logic [31:0] seq [4]     = '{32'h00221820, 32'h00642820, 32'h00642820, NOP};
    logic        br [4]      = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [4:0]  want [4]    = '{5'b11000, 5'b11111, 5'b11110, 5'b11000};
    logic [1:0]  want_st [4] = '{2'd0, 2'd0, 2'd2, 2'd0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(seq[i], 1'b1, br[i]);
      checks++;
      if ({pc_en, ifid_en, ifid_nop, idex_nop, exmem_nop} !== want[i] || seq_state !== want_st[i]) begin
        failures++;
        $display("FAIL branch_flush cyc%0d ctl=%b st=%b want ctl=%b st=%b", i,
                 {pc_en, ifid_en, ifid_nop, idex_nop, exmem_nop}, seq_state, want[i], want_st[i]);
      end
      tick();
    end
    checks++;
    if (flush_count !== 4'd1 || stall_count !== 4'd0) begin
      failures++;
      $display("FAIL branch_flush_count fc=%0d sc=%0d want fc=1 sc=0", flush_count, stall_count);
    end
  endtask

  task automatic test_jump();
    logic [31:0] seq [5]     = '{32'h08000010, NOP, 32'h08000010, 32'h08000010, NOP};
    logic        br [5]      = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [4:0]  want [5]    = '{5'b11100, 5'b11000, 5'b11111, 5'b11110, 5'b11000};
    logic [1:0]  want_st [5] = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(seq[i], 1'b1, br[i]);
      checks++;
      if ({pc_en, ifid_en, ifid_nop, idex_nop, exmem_nop} !== want[i] || seq_state !== want_st[i]) begin
        failures++;
        $display("FAIL jump cyc%0d ctl=%b st=%b want ctl=%b st=%b", i,
                 {pc_en, ifid_en, ifid_nop, idex_nop, exmem_nop}, seq_state, want[i], want_st[i]);
      end
      tick();
    end
    checks++;
    if (flush_count !== 4'd1) begin
      failures++;
      $display("FAIL jump_flush_count fc=%0d want 1", flush_count);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int r = 0; r < 6; r++) begin
      drive(32'h00221820, 1'b1, 1'b0);
      tick();
      repeat (4) begin
        drive(32'h00642820, 1'b1, 1'b0);
        tick();
      end
    end
    repeat (20) begin
      drive(NOP, 1'b1, 1'b1);
      tick();
    end
    checks++;
    if (stall_count !== 4'hF || flush_count !== 4'hF) begin
      failures++;
      $display("FAIL saturation sc=%0d fc=%0d want sc=15 fc=15", stall_count, flush_count);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0]  ops [12] = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h23, 6'h2B, 6'h04, 6'h05,
                              6'h02, 6'h3F, 6'h11};
    logic [31:0] ins;
    ins        = $urandom;
    ins[31:26] = ops[$urandom_range(11, 0)];
    ins[25:21] = 5'($urandom_range(4, 0));
    ins[20:16] = 5'($urandom_range(4, 0));
    ins[15:11] = 5'($urandom_range(4, 0));
    return ins;
  endfunction

  task automatic test_random();
    logic [4:0] exp_ctl;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      drive(rand_instr(), ($urandom_range(7, 0) != 0), ($urandom_range(9, 0) == 0));
      exp_ctl = m_expect();
      checks++;
      if ({pc_en, ifid_en, ifid_nop, idex_nop, exmem_nop} !== exp_ctl || seq_state !== 2'(m_mode)) begin
        failures++;
        if (failures < 20)
          $display("FAIL random_ctl cyc%0d ins=%h ctl=%b st=%b want ctl=%b st=%b", i, id_instr,
                   {pc_en, ifid_en, ifid_nop, idex_nop, exmem_nop}, seq_state, exp_ctl, 2'(m_mode));
      end
      checks++;
      if (stall_count !== CW'(m_stalls) || flush_count !== CW'(m_flushes)) begin
        failures++;
        if (failures < 20)
          $display("FAIL random_count cyc%0d sc=%0d fc=%0d want sc=%0d fc=%0d", i,
                   stall_count, flush_count, m_stalls, m_flushes);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_raw_stall();
    test_zero_reg();
    test_lw_sw();
    test_branch_flush();
    test_jump();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
